// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix drive/return, raw button, and conditioned outputs.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [2:0] cols;
  logic       pushbutton_raw;
  logic [3:0] keypad;
  logic       key_valid;
  logic       pushbutton;

  // Scanner side.
  modport master (
    output rows,
    output keypad,
    output key_valid,
    output pushbutton,
    input  cols,
    input  pushbutton_raw
  );

  // Keypad / downstream FSM side.
  modport slave (
    input  rows,
    input  keypad,
    input  key_valid,
    input  pushbutton,
    output cols,
    output pushbutton_raw
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 active-low matrix keypad scanner with key and pushbutton debouncing.
// Produces a held key code (1..12, 0 = none) with a one-cycle key_valid pulse,
// and a one-cycle pulse per debounced pushbutton press.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS   = 4,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master bus
);

  localparam int unsigned MaxCnt = (SCAN_TICKS > DEBOUNCE_CNT) ? SCAN_TICKS : DEBOUNCE_CNT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_TICKS - 1);
  localparam logic [CntW-1:0] DebDone  = CntW'(DEBOUNCE_CNT);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e          state_q, state_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [3:0]      keypad_q, keypad_d;
  logic            key_valid_q, key_valid_d;

  logic [2:0]      cols_s1_q, cols_s2_q;
  logic            btn_s1_q, btn_s2_q;
  logic            btn_level_q, btn_level_d;
  logic [CntW-1:0] btn_cnt_q, btn_cnt_d;
  logic            pushbutton_q, pushbutton_d;

  logic            any_low;
  logic [1:0]      first_low;
  logic            cand_low;
  logic [3:0]      key_code;
  logic [CntW-1:0] scan_inc, deb_inc, btn_inc;

  // Two-flop synchronizers for the asynchronous column returns and button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cols_s1_q <= 3'b111;
      cols_s2_q <= 3'b111;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
    end else begin
      cols_s1_q <= bus.cols;
      cols_s2_q <= cols_s1_q;
      btn_s1_q  <= bus.pushbutton_raw;
      btn_s2_q  <= btn_s1_q;
    end
  end

  // Column decode and saturating increments shared by the FSM and button logic.
  always_comb begin
    any_low   = ~&cols_s2_q;
    first_low = 2'd2;
    if (!cols_s2_q[0]) begin
      first_low = 2'd0;
    end else if (!cols_s2_q[1]) begin
      first_low = 2'd1;
    end
    cand_low = 1'b0;
    case (cand_col_q)
      2'd0:    cand_low = ~cols_s2_q[0];
      2'd1:    cand_low = ~cols_s2_q[1];
      2'd2:    cand_low = ~cols_s2_q[2];
      default: cand_low = 1'b0;
    endcase
    key_code = {2'b00, row_idx_q} * 4'd3 + {2'b00, cand_col_q} + 4'd1;
    scan_inc = (scan_cnt_q == CntSat) ? scan_cnt_q : scan_cnt_q + CntW'(1);
    deb_inc  = (deb_cnt_q == CntSat) ? deb_cnt_q : deb_cnt_q + CntW'(1);
    btn_inc  = (btn_cnt_q == CntSat) ? btn_cnt_q : btn_cnt_q + CntW'(1);
  end

  // Scan / debounce / held FSM next state.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    cand_col_d  = cand_col_q;
    keypad_d    = keypad_q;
    key_valid_d = 1'b0;
    unique case (state_q)
      StScan: begin
        if (scan_cnt_q >= ScanLast) begin
          scan_cnt_d = '0;
          if (any_low) begin
            cand_col_d = first_low;
            deb_cnt_d  = '0;
            state_d    = StDebounce;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_inc;
        end
      end
      StDebounce: begin
        if (cand_low) begin
          if (deb_inc == DebDone) begin
            keypad_d    = key_code;
            key_valid_d = 1'b1;
            deb_cnt_d   = '0;
            state_d     = StHeld;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end else begin
          // Bounce during press: abandon this candidate and move on.
          row_idx_d  = row_idx_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
          state_d    = StScan;
        end
      end
      StHeld: begin
        if (!cand_low) begin
          if (deb_inc == DebDone) begin
            keypad_d   = 4'd0;
            row_idx_d  = row_idx_q + 2'd1;
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
            state_d    = StScan;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end else begin
          // Release bounce: any low sample restarts the release count.
          deb_cnt_d = '0;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Pushbutton debounce next state; pulse only on a debounced rising flip.
  always_comb begin
    btn_level_d  = btn_level_q;
    btn_cnt_d    = '0;
    pushbutton_d = 1'b0;
    if (btn_s2_q != btn_level_q) begin
      if (btn_inc == DebDone) begin
        btn_level_d  = btn_s2_q;
        pushbutton_d = btn_s2_q;
      end else begin
        btn_cnt_d = btn_inc;
      end
    end
  end

  // State registers for FSM and pushbutton debounce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StScan;
      row_idx_q    <= 2'd0;
      scan_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      cand_col_q   <= 2'd0;
      keypad_q     <= 4'd0;
      key_valid_q  <= 1'b0;
      btn_level_q  <= 1'b0;
      btn_cnt_q    <= '0;
      pushbutton_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      scan_cnt_q   <= scan_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      cand_col_q   <= cand_col_d;
      keypad_q     <= keypad_d;
      key_valid_q  <= key_valid_d;
      btn_level_q  <= btn_level_d;
      btn_cnt_q    <= btn_cnt_d;
      pushbutton_q <= pushbutton_d;
    end
  end

  assign bus.rows       = ~(4'b0001 << row_idx_q);
  assign bus.keypad     = keypad_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.pushbutton = pushbutton_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-conditioning stage directly upstream of the vending-machine fsm. Scans a 4x3 active-low matrix keypad, synchronizes and debounces the column returns and the raw pushbutton, and delivers a clean keypad code (0 = no key) plus a one-cycle debounced pushbutton press pulse. Its keypad and pushbutton outputs connect straight to the fsm inputs of the same names.

Parameters:
SCAN_TICKS, 4, clock cycles each row is driven before its columns are sampled (minimum 3).
DEBOUNCE_CNT, 8, consecutive stable synchronized cycles required to accept a press or a release.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
rows  output  4  row drive, one-hot active-low (exactly one bit 0 at all times)
cols  input  3  column returns, active-low, asynchronous to clk
pushbutton_raw  input  1  raw start button, active-high, asynchronous
keypad  output  4  debounced key code, held while the key is down; 4'b0000 when no key
key_valid  output  1  one-cycle pulse in the cycle keypad takes a new nonzero code
pushbutton  output  1  one-cycle pulse per debounced press

Behaviour:
- Reset (reset==0 at a clock edge): rows=4'b1110 (row 0), keypad=0, key_valid=0, pushbutton=0, state=SCAN, all counters 0, column sync flops=3'b111, button sync flops=0, debounced button level=0. A mid-operation reset aborts any press; no pulse is issued.
- Synchronization: cols and pushbutton_raw each pass through 2 flops. All decisions use synchronized values only.
- Key code: row r (0..3), column c (0..2) -> code r*3+c+1, so the range is 1..12. Codes 13..15 are never produced.
- FSM states: SCAN, DEBOUNCE, HELD.
- SCAN: drive row_idx and count cycles 0..SCAN_TICKS-1. On the last count, sample synced cols.
  - If any column is low, latch the candidate column (lowest index wins when several are low), clear the debounce counter and go to DEBOUNCE. row_idx does not change.
  - Otherwise advance row_idx as 3 wraps to 0, and restart the count.
- DEBOUNCE: keep the row driven.
  - Each cycle the candidate column reads low, increment the counter.
  - If the candidate column reads high, return to SCAN on the next row. keypad is unchanged and no pulse is issued.
  - When the counter reaches DEBOUNCE_CNT, in that same cycle set keypad to the code, pulse key_valid and go to HELD.
- HELD: keep the row driven. keypad holds the code. Other keys are ignored, even in the same row.
  - Count consecutive cycles with the candidate column high. Any low sample clears the count (bounce on release).
  - When the count reaches DEBOUNCE_CNT, set keypad=0 and go to SCAN on the next row.
- Pushbutton debounce runs independently of the FSM.
  - When the synced level differs from the debounced level for DEBOUNCE_CNT consecutive cycles, the debounced level flips. Any disagreement gap clears the count.
  - A debounced 0->1 flip raises pushbutton for exactly one cycle.
  - A held button produces no further pulses. Release produces no pulse.
- Simultaneous keypad and button activity is handled independently. Both pulses may occur in the same cycle.
- Counter widths are $clog2(max(SCAN_TICKS, DEBOUNCE_CNT)+1). Counters saturate and never wrap.

Test Plan:
- Reset held 3 cycles, cols=3'b111 -> rows=1110, keypad=0, key_valid=0, pushbutton=0. After release, rows cycles 1110->1101->1011->0111->1110, changing every 4 cycles.
- Hold cols=3'b110 only while rows=1110, stably -> within 2+4+8+2 cycles of the row being driven, keypad=4'b0001 with a single key_valid pulse. keypad returns to 0 about 10 cycles after cols goes back to 111.
- Press row 3 col 2 -> keypad=4'd12. Press row 1, cols=3'b100 (col 0 and col 1 both low) -> keypad=4'd4, the lowest column.
- Bounce: col toggles low/high every 3 cycles during DEBOUNCE -> keypad stays 0, no key_valid, scanning resumes. Bounces of fewer than 8 cycles on release -> keypad holds its code.
- pushbutton_raw high for 20 cycles, with a 2-cycle glitch to 0 at cycle 5 -> exactly one pushbutton pulse. A 5-cycle raw pulse alone -> no pulse.
- Assert reset while in HELD with keypad=1 -> next cycle keypad=0, rows=1110, state=SCAN. Key still held after reset -> re-detected and a fresh key_valid is issued.
